// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the N-channel debouncer.
package debounce_pkg;

    localparam int unsigned DefStableCnt = 3;
    localparam int unsigned DefTickDiv   = 1;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: stability counter, registered level and rise/fall strobes.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CNT   = DefStableCnt,
    parameter bit          FAST_RELEASE = 1'b0
) (
    input  logic cclk,
    input  logic clr_n,
    input  logic tick_i,
    input  logic s_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned     CntW   = clog2_min1(STABLE_CNT);
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CNT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;

    always_ff @(posedge cclk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (tick_i) begin
            if (s_i == level_q) begin
                cnt_d = '0;
            // A release bypasses the filter entirely when FAST_RELEASE is set.
            end else if ((FAST_RELEASE && level_q) || (cnt_q == CntMax)) begin
                level_d = s_i;
                cnt_d   = '0;
                rise_d  = s_i;
                fall_d  = ~s_i;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/debounce_n.sv
// N-channel debouncer: 2-FF synchronisers, shared sample-tick prescaler, per-channel filters.
module debounce_n
    import debounce_pkg::*;
#(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned STABLE_CNT   = DefStableCnt,
    parameter int unsigned TICK_DIV     = DefTickDiv,
    parameter bit          FAST_RELEASE = 1'b0
) (
    input  logic             cclk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] inp,
    output logic [WIDTH-1:0] outp,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             tick
);

    localparam int unsigned     DivW   = clog2_min1(TICK_DIV);
    localparam logic [DivW-1:0] DivMax = DivW'(TICK_DIV - 1);

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [DivW-1:0]  div_q, div_d;
    logic             tick_q, tick_d;

    always_ff @(posedge cclk or negedge clr_n) begin
        if (!clr_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            s1_q   <= inp;
            s2_q   <= s1_q;
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    always_comb begin
        tick_d = (div_q == DivMax);
        div_d  = tick_d ? '0 : div_q + DivW'(1);
    end

    assign tick = tick_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_chan #(
            .STABLE_CNT  (STABLE_CNT),
            .FAST_RELEASE(FAST_RELEASE)
        ) u_chan (
            .cclk   (cclk),
            .clr_n  (clr_n),
            .tick_i (tick_q),
            .s_i    (s2_q[i]),
            .level_o(outp[i]),
            .rise_o (rise[i]),
            .fall_o (fall[i])
        );
    end

endmodule

// File: tb/tb_debounce_n.sv
// Randomised bench for debounce_n: three configurations checked against a behavioural model.
module tb_debounce_n;

    localparam int unsigned W  = 4;
    localparam int unsigned SC = 3;

    logic         cclk = 1'b0;
    logic         clr_n;
    logic [W-1:0] inp;

    logic [W-1:0] outp_a, rise_a, fall_a;
    logic [W-1:0] outp_b, rise_b, fall_b;
    logic [W-1:0] outp_c, rise_c, fall_c;
    logic         tick_a, tick_b, tick_c;

    int total = 0;
    int bad   = 0;

    always #5 cclk = ~cclk;

    // a: defaults, b: TICK_DIV=4, c: FAST_RELEASE=1
    debounce_n #(.WIDTH(W), .STABLE_CNT(SC), .TICK_DIV(1), .FAST_RELEASE(1'b0)) u_dut_a (
        .cclk(cclk), .clr_n(clr_n), .inp(inp),
        .outp(outp_a), .rise(rise_a), .fall(fall_a), .tick(tick_a)
    );
    debounce_n #(.WIDTH(W), .STABLE_CNT(SC), .TICK_DIV(4), .FAST_RELEASE(1'b0)) u_dut_b (
        .cclk(cclk), .clr_n(clr_n), .inp(inp),
        .outp(outp_b), .rise(rise_b), .fall(fall_b), .tick(tick_b)
    );
    debounce_n #(.WIDTH(W), .STABLE_CNT(SC), .TICK_DIV(1), .FAST_RELEASE(1'b1)) u_dut_c (
        .cclk(cclk), .clr_n(clr_n), .inp(inp),
        .outp(outp_c), .rise(rise_c), .fall(fall_c), .tick(tick_c)
    );

    // Reference model state, one slot per configuration.
    int           div_cfg[3]  = '{1, 4, 1};
    bit           fast_cfg[3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] m_out[3];
    logic [W-1:0] m_rise[3];
    logic [W-1:0] m_fall[3];
    logic         m_tick[3];
    int           m_run[3][W];
    logic [W-1:0] seen[$];
    int           edges;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_out[k]  = '0;
            m_rise[k] = '0;
            m_fall[k] = '0;
            m_tick[k] = 1'b0;
            for (int c = 0; c < W; c++) m_run[k][c] = 0;
        end
        seen.delete();
        edges = 0;
    endtask

    // One rising edge with reset released; x is the raw input at that edge.
    task automatic model_step(input logic [W-1:0] x);
        logic [W-1:0] s2;
        edges++;
        // The filter sees the raw input from two edges earlier.
        s2 = (seen.size() >= 2) ? seen[seen.size()-2] : '0;
        for (int k = 0; k < 3; k++) begin
            m_rise[k] = '0;
            m_fall[k] = '0;
            if (m_tick[k]) begin
                for (int c = 0; c < W; c++) begin
                    if (s2[c] == m_out[k][c]) begin
                        m_run[k][c] = 0;
                    end else if (fast_cfg[k] && m_out[k][c]) begin
                        m_out[k][c]  = 1'b0;
                        m_fall[k][c] = 1'b1;
                        m_run[k][c]  = 0;
                    end else begin
                        m_run[k][c]++;
                        if (m_run[k][c] == SC) begin
                            m_out[k][c] = s2[c];
                            if (s2[c]) m_rise[k][c] = 1'b1;
                            else       m_fall[k][c] = 1'b1;
                            m_run[k][c] = 0;
                        end
                    end
                end
            end
            m_tick[k] = ((edges % div_cfg[k]) == 0);
        end
        seen.push_back(x);
        if (seen.size() > 2) void'(seen.pop_front());
    endtask

    task automatic check_all();
        check("a_outp", outp_a, m_out[0]);
        check("a_rise", rise_a, m_rise[0]);
        check("a_fall", fall_a, m_fall[0]);
        check("a_tick", tick_a, m_tick[0]);
        check("b_outp", outp_b, m_out[1]);
        check("b_rise", rise_b, m_rise[1]);
        check("b_fall", fall_b, m_fall[1]);
        check("b_tick", tick_b, m_tick[1]);
        check("c_outp", outp_c, m_out[2]);
        check("c_rise", rise_c, m_rise[2]);
        check("c_fall", fall_c, m_fall[2]);
        check("c_tick", tick_c, m_tick[2]);
    endtask

    task automatic cycle();
        @(posedge cclk);
        if (clr_n) model_step(inp);
        @(negedge cclk);
        check_all();
    endtask

    function automatic logic [W-1:0] get_out(input int inst);
        case (inst)
            0:       return outp_a;
            1:       return outp_b;
            default: return outp_c;
        endcase
    endfunction

    // Cycles (counting the first edge as 1) until channel ch of inst reads val; 0 if never.
    task automatic measure(input int inst, input int ch, input logic val, output int lat);
        logic [W-1:0] o;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            cycle();
            o = get_out(inst);
            if (lat == 0 && o[ch] == val) lat = i;
            if (lat != 0) break;
        end
    endtask

    task automatic async_reset_pulse();
        #2 clr_n = 1'b0;
        model_reset();
        #1;
        check("rst_async_outp", {outp_a, outp_b, outp_c}, '0);
        check("rst_async_strb", {rise_a, fall_a, rise_c, fall_c}, '0);
        cycle();
        clr_n = 1'b1;
    endtask

    initial begin
        int  lat;
        int  nticks;
        bit  saw_rise;

        clr_n = 1'b0;
        inp   = 4'hF;
        model_reset();

        // Reset held with all inputs high, then release.
        repeat (3) cycle();
        check("rst_outp", outp_a, 4'h0);
        clr_n = 1'b1;
        measure(0, 0, 1'b1, lat);
        check("rst_lat", lat, 5);
        check("rst_outp_all", outp_a, 4'hF);
        check("rst_rise", rise_a, 4'hF);
        repeat (20) cycle();

        // Short glitch on channel 0 must not propagate.
        inp = 4'h0;
        repeat (20) cycle();
        saw_rise = 1'b0;
        inp[0] = 1'b1;
        repeat (2) cycle();
        inp[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (rise_a[0]) saw_rise = 1'b1;
        end
        check("glitch_rise", saw_rise, 1'b0);
        check("glitch_outp", outp_a[0], 1'b0);

        // Bouncing edge on channel 1.
        for (int i = 0; i < 4; i++) begin
            inp[1] = ~inp[1];
            cycle();
        end
        inp[1] = 1'b1;
        measure(0, 1, 1'b1, lat);
        check("bounce_lat", lat, 5);

        // Tick prescaler on instance b: one tick per four cycles.
        nticks = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (tick_b) nticks++;
        end
        check("tick_count", nticks, 10);
        check("tick_div_outp", outp_b[1], 1'b1);

        // Fast release on instance c.
        inp[1] = 1'b0;
        measure(2, 1, 1'b0, lat);
        check("fast_lat", lat, 3);
        check("fast_fall", fall_c[1], 1'b1);
        repeat (20) cycle();

        // Reset in the middle of a count discards it.
        inp = 4'h0;
        repeat (10) cycle();
        inp[0] = 1'b1;
        repeat (4) cycle();
        async_reset_pulse();
        measure(0, 0, 1'b1, lat);
        check("midrst_lat", lat, 5);

        // Randomised phase.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset_pulse();
            end
            if ($urandom_range(0, 39) == 0) begin
                inp = ~inp;
            end else begin
                for (int c = 0; c < W; c++) begin
                    if ($urandom_range(0, 7) == 0) inp[c] = ~inp[c];
                end
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
